audio_fir_mac: RTL
==================

// Module: audio_fir_mac
// PURPOSE
//  Time-multiplexed stereo FIR filter between the codec serial interface's record and playback sides.
//  - Consumes LeftRecData/RightRecData on each NewFrame.
//  - Runs one shared multiply-accumulate over TAPS coefficients per channel.
//  - Drives LeftPlayData/RightPlayData back to the codec for the next frame.
//  - Runs on the codec master clock; one frame = 256 clk cycles.
// PARAMETERS
//  N     24  sample width, signed two's complement
//  TAPS  16  filter length; legal range 2..126 (must finish within one frame)
//  CW    18  coefficient width, signed Q1.(CW-1)
// PORTS
//  clk            in   1        codec master clock (same clock as the serial interface)
//  reset          in   1        asynchronous, active-low; all state cleared while low
//  NewFrame       in   1        frame marker from the serial interface, level, clk-synchronous
//  LeftRecData    in   N        captured left ADC sample
//  RightRecData   in   N        captured right ADC sample
//  bypass         in   1        1: play = rec (same latency), coefficients unused
//  coef_wr        in   1        coefficient write strobe
//  coef_addr      in   clog2(TAPS)  tap index; index 0 multiplies the newest sample
//  coef_data      in   CW       coefficient value
//  busy           out  1        high from capture through output update
//  done           out  1        one-cycle pulse when play outputs update
//  overrun        out  1        sticky; frame arrived while busy
//  LeftPlayData   out  N        filtered left sample, registered
//  RightPlayData  out  N        filtered right sample, registered
// BEHAVIOUR
//  Reset (reset low): async clear of all state.
//   - Outputs busy, done, overrun = 0; play data = 0.
//   - Coefficients = 0; delay lines = 0; FSM in IDLE.
//  Start: rising edge of NewFrame, detected by registering NewFrame and testing prev=0, now=1.
//   - Edge cycle = cycle 0. High-level holds do not retrigger.
//  FSM: IDLE -> CAPT -> MAC_L -> MAC_R -> OUT -> IDLE.
//   - CAPT (cycle 1): each channel's delay line shifts by one; the rec sample enters tap 0;
//     accumulators cleared; busy=1.
//   - MAC_L: TAPS cycles, k=0..TAPS-1, acc_l += x_l[k]*c[k].
//   - MAC_R: TAPS cycles, k=0..TAPS-1, acc_r += x_r[k]*c[k].
//   - OUT (cycle 2*TAPS+2): both play outputs load together; done=1 for this cycle only;
//     busy drops the next cycle.
//  Fixed latency 2*TAPS+2 cycles from the edge cycle to done (TAPS=16: 34).
//  Arithmetic:
//   - Product width N+CW; accumulator width N+CW+clog2(TAPS), sign-extended, no wrap.
//   - Result = (acc + 2^(CW-2)) >>> (CW-1), arithmetic shift, round half up.
//   - Result saturates to [-2^(N-1), 2^(N-1)-1].
//  Bypass: sampled at CAPT.
//   - Delay lines still shift.
//   - At OUT, play = the captured rec samples unchanged.
//  Coefficient writes:
//   - Accepted only while busy=0; take effect the next cycle.
//   - coef_wr while busy=1 is dropped; no flag raised.
//   - coef_addr >= TAPS is ignored.
//  Overrun: a NewFrame rising edge while busy=1 is ignored and sets overrun=1.
//   - The current computation continues unaffected.
//   - overrun clears only on reset.
//  An edge coinciding with the OUT cycle counts as busy (overrun); the edge on the cycle
//  after OUT starts normally.
//  Reset asserted mid-computation aborts immediately:
//   - No done pulse.
//   - Play outputs and history are zeroed.
// TESTING
//  - Reset, write c[0]=2^(CW-1)-1, rest 0; rec L=0x100000, R=-0x100000; pulse NewFrame.
//    -> done exactly 34 cycles after the edge; L=0x0FFFF8, R=-0x0FFFF8 (rounded).
//  - Impulse: c[k]=k*1024; L rec = 0x001000 then 0 for 20 frames.
//    -> frame j output equals (0x1000*j*1024+2^16)>>>17 for j<16, then 0.
//  - Saturation: all c = 2^(CW-1)-1; rec L=0x7FFFFF for 16 frames.
//    -> L play = 0x7FFFFF, never wraps negative.
//  - NewFrame edge at cycle 10 of a computation -> overrun=1, done still at cycle 34,
//    no second done; overrun stays 1 until reset.
//  - coef_wr while busy -> coefficient unchanged on readback via impulse response.
//    bypass=1 -> play equals rec after 34 cycles.
//  - Assert reset at cycle 20 of MAC -> busy=0 and play=0 immediately, no done.
//    Next frame after release -> output 0 with default zero coefficients.

Source files
------------

// File: rtl/audio_fir_mac.sv
// audio_fir_mac
//   Time-multiplexed stereo FIR filter between the codec serial interface's
//   record and playback sides. One shared multiplier runs TAPS
//   multiply-accumulate steps for the left channel and then TAPS steps for
//   the right channel. Both play outputs update together.
//
// Ports
//   clk            codec master clock (one frame = 256 cycles)
//   reset          asynchronous, active-low clear of all state
//   NewFrame       frame marker (level); its rising edge starts a computation
//   LeftRecData    captured left ADC sample (signed, N bits)
//   RightRecData   captured right ADC sample (signed, N bits)
//   bypass         1: play = rec with the same latency; sampled at capture
//   coef_wr        coefficient write strobe (accepted only while busy = 0)
//   coef_addr      tap index; index 0 multiplies the newest sample
//   coef_data      coefficient value, signed Q1.(CW-1)
//   busy           high from capture through the output update cycle
//   done           one-cycle pulse in the cycle the play outputs update
//   overrun        sticky; a frame edge arrived while busy
//   LeftPlayData   filtered left sample, registered
//   RightPlayData  filtered right sample, registered
//
// Handshake: a NewFrame rising edge with busy = 0 is accepted in that same
// cycle (cycle 0); busy rises in cycle 1 and the result is presented with a
// done pulse in cycle 2*TAPS+2; busy falls one cycle later. An edge seen
// while busy = 1 is not accepted and only sets overrun.

module audio_fir_mac #(
    parameter int N    = 24,
    parameter int TAPS = 16,
    parameter int CW   = 18
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    NewFrame,
    input  logic [N-1:0]            LeftRecData,
    input  logic [N-1:0]            RightRecData,
    input  logic                    bypass,
    input  logic                    coef_wr,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [CW-1:0]           coef_data,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun,
    output logic [N-1:0]            LeftPlayData,
    output logic [N-1:0]            RightPlayData
);

    localparam int KW = $clog2(TAPS);
    localparam int PW = N + CW;
    localparam int AW = N + CW + KW;
    localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

    // Rounding/saturation constants, one bit wider than the accumulator so
    // the half-LSB addition can never wrap.
    localparam logic signed [AW:0] RND   = {{(AW + 2 - CW){1'b0}}, 1'b1, {(CW - 2){1'b0}}};
    localparam logic signed [AW:0] MAX_V = {{(AW + 2 - N){1'b0}}, {(N - 1){1'b1}}};
    localparam logic signed [AW:0] MIN_V = {{(AW + 2 - N){1'b1}}, {(N - 1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        CAPT,
        MAC_L,
        MAC_R,
        OUT
    } state_t;

    state_t               state;
    logic                 nf_q;
    logic                 byp;
    logic [KW-1:0]        k;
    logic signed [N-1:0]  x_l  [TAPS];
    logic signed [N-1:0]  x_r  [TAPS];
    logic signed [CW-1:0] coef [TAPS];
    logic signed [AW-1:0] acc_l;
    logic signed [AW-1:0] acc_r;

    logic                 frame_edge;
    logic signed [N-1:0]  sel_x;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc_next;

    assign frame_edge = NewFrame & ~nf_q;

    // Shared multiplier: the state picks which channel's history feeds it
    // and which accumulator it adds into.
    always_comb begin
        sel_x    = (state == MAC_L) ? x_l[k] : x_r[k];
        prod     = sel_x * coef[k];
        acc_next = ((state == MAC_L) ? acc_l : acc_r) + {{KW{prod[PW-1]}}, prod};
    end

    // Round half up, arithmetic shift back to sample scale, then clamp.
    function automatic logic [N-1:0] round_sat(input logic signed [AW-1:0] a);
        logic signed [AW:0] t;
        t = ($signed({a[AW-1], a}) + RND) >>> (CW - 1);
        if (t > MAX_V) begin
            return MAX_V[N-1:0];
        end else if (t < MIN_V) begin
            return MIN_V[N-1:0];
        end else begin
            return t[N-1:0];
        end
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            nf_q          <= 1'b0;
            byp           <= 1'b0;
            k             <= '0;
            acc_l         <= '0;
            acc_r         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overrun       <= 1'b0;
            LeftPlayData  <= '0;
            RightPlayData <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x_l[i]  <= '0;
                x_r[i]  <= '0;
                coef[i] <= '0;
            end
        end else begin
            nf_q <= NewFrame;
            done <= 1'b0;

            // Coefficients are frozen while a computation is in flight.
            if (coef_wr && !busy && (32'(coef_addr) < TAPS)) begin
                coef[coef_addr] <= coef_data;
            end

            if (frame_edge && busy) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (frame_edge) begin
                        state <= CAPT;
                        busy  <= 1'b1;
                    end
                end
                CAPT: begin
                    for (int i = TAPS - 1; i > 0; i--) begin
                        x_l[i] <= x_l[i-1];
                        x_r[i] <= x_r[i-1];
                    end
                    x_l[0] <= LeftRecData;
                    x_r[0] <= RightRecData;
                    acc_l  <= '0;
                    acc_r  <= '0;
                    k      <= '0;
                    byp    <= bypass;
                    state  <= MAC_L;
                end
                MAC_L: begin
                    acc_l <= acc_next;
                    if (k == K_LAST) begin
                        k     <= '0;
                        state <= MAC_R;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                MAC_R: begin
                    acc_r <= acc_next;
                    if (k == K_LAST) begin
                        // The final right product is folded in here so both
                        // outputs load on the same edge that enters OUT.
                        k             <= '0;
                        state         <= OUT;
                        done          <= 1'b1;
                        LeftPlayData  <= byp ? x_l[0] : round_sat(acc_l);
                        RightPlayData <= byp ? x_r[0] : round_sat(acc_next);
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                OUT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
